// File: rtl/router_arb4.sv
// rtl/router_arb4.sv - round-robin frame arbiter for one router output port
module router_arb4 #(
    parameter int NumPorts  = 4,
    parameter int PortNo    = 1,
    parameter int GapCycles = 2,
    parameter int TimeoutW  = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NumPorts-1:0]      D_SOF,
    input  logic [NumPorts-1:0][7:0] DEST,
    input  logic [NumPorts-1:0]      D_EOF,
    input  logic [NumPorts-1:0]      D_VALID,
    input  logic                     Q_BP,
    output logic [NumPorts-1:0]      SRC_PORT,
    output logic [NumPorts-1:0]      D_BP,
    output logic [NumPorts-1:0]      PENDING,
    output logic                     BUSY,
    output logic                     TIMEOUT,
    output logic [15:0]              FRAME_CNT
);

    localparam int                  IW       = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam logic [IW-1:0]       LAST_RST = IW'(NumPorts - 1);
    localparam logic [2:0]          GAP_INIT = 3'(GapCycles - 1);
    // Watchdog fires on the stalled cycle that would carry the count to all-ones
    localparam logic [TimeoutW-1:0] WD_LAST  = {{(TimeoutW-1){1'b1}}, 1'b0};
    localparam logic [NumPorts-1:0] ONE      = NumPorts'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state;
    logic [IW-1:0]       last;
    logic [2:0]          gap_cnt;
    logic [TimeoutW-1:0] wd_cnt;

    logic [NumPorts-1:0] req;
    logic [IW-1:0]       sel;
    logic                found;
    logic                eof_det;
    logic                active;

    // Frame-start requests aimed at this output port
    always_comb begin
        req = '0;
        for (int i = 0; i < NumPorts; i++) begin
            req[i] = D_SOF[i] && (DEST[i] == 8'(PortNo));
        end
    end

    // Round-robin pick: first requester after the last winner, wrapping around
    always_comb begin
        sel   = last;
        found = 1'b0;
        for (int k = 1; k <= NumPorts; k++) begin
            if (!found && req[IW'((int'(last) + k) % NumPorts)]) begin
                sel   = IW'((int'(last) + k) % NumPorts);
                found = 1'b1;
            end
        end
    end

    // Granted-source frame end and liveness, used only while in GRANT
    always_comb begin
        eof_det = |(SRC_PORT & D_EOF & D_VALID);
        active  = (|(SRC_PORT & D_VALID)) | Q_BP;
    end

    // Losers are stalled rather than dropped; the winner sees output backpressure
    always_comb begin
        D_BP    = (SRC_PORT & {NumPorts{Q_BP}}) | (req & ~SRC_PORT);
        PENDING = req & ~SRC_PORT;
        BUSY    = (state != IDLE);
    end

    // Arbiter FSM with grant, watchdog, gap timer and frame counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            SRC_PORT  <= '0;
            last      <= LAST_RST;
            gap_cnt   <= 3'd0;
            wd_cnt    <= '0;
            TIMEOUT   <= 1'b0;
            FRAME_CNT <= 16'd0;
        end else begin
            TIMEOUT <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        SRC_PORT <= ONE << sel;
                        last     <= sel;
                        wd_cnt   <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // EOF takes priority over a coincident watchdog expiry
                    if (eof_det) begin
                        SRC_PORT  <= '0;
                        FRAME_CNT <= FRAME_CNT + 16'd1;
                        gap_cnt   <= GAP_INIT;
                        wd_cnt    <= '0;
                        state     <= GAP;
                    end else if (active) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        TIMEOUT  <= 1'b1;
                        SRC_PORT <= '0;
                        gap_cnt  <= GAP_INIT;
                        wd_cnt   <= '0;
                        state    <= GAP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 3'd0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    SRC_PORT <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_arb4.sv
// tb/tb_router_arb4.sv - randomized and directed bench for router_arb4
module tb_router_arb4;

    localparam int GAPC = 2;
    localparam int TMAX = 255;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [3:0]      D_SOF, D_EOF, D_VALID;
    logic [3:0][7:0] DEST;
    logic            Q_BP;
    logic [3:0]      SRC_PORT, D_BP, PENDING;
    logic            BUSY, TIMEOUT;
    logic [15:0]     FRAME_CNT;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    router_arb4 #(.NumPorts(4), .PortNo(1), .GapCycles(GAPC), .TimeoutW(8)) dut (
        .CLK(CLK), .RST(RST), .D_SOF(D_SOF), .DEST(DEST), .D_EOF(D_EOF),
        .D_VALID(D_VALID), .Q_BP(Q_BP), .SRC_PORT(SRC_PORT), .D_BP(D_BP),
        .PENDING(PENDING), .BUSY(BUSY), .TIMEOUT(TIMEOUT), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: granted port index (-1 none), last winner, remaining gap
    // cycles, consecutive stalled cycles, completed frames, timeout pulse.
    int          m_gnt   = -1;
    int          m_last  = 3;
    int          m_gap   = 0;
    int          m_stall = 0;
    logic [15:0] m_fcnt  = 16'd0;
    bit          m_to    = 1'b0;

    function automatic logic [3:0] m_req();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = D_SOF[i] && (DEST[i] == 8'd1);
        return r;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_gnt <= -1; m_last <= 3; m_gap <= 0; m_stall <= 0; m_fcnt <= 16'd0; m_to <= 1'b0;
        end else begin : step
            int g, l, gp, st;
            logic [15:0] f;
            bit t, done;
            logic [3:0] r;
            g = m_gnt; l = m_last; gp = m_gap; st = m_stall; f = m_fcnt; t = 1'b0;
            r = m_req();
            if (g >= 0) begin
                if (D_EOF[g] && D_VALID[g]) begin
                    g = -1; f = f + 16'd1; gp = GAPC; st = 0;
                end else if (D_VALID[g] || Q_BP) begin
                    st = 0;
                end else begin
                    st = st + 1;
                    if (st == TMAX) begin
                        t = 1'b1; g = -1; gp = GAPC; st = 0;
                    end
                end
            end else if (gp > 0) begin
                gp = gp - 1;
            end else if (r != 4'b0) begin
                done = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (!done && r[(l + k) % 4]) begin
                        g = (l + k) % 4; done = 1'b1; st = 0;
                    end
                end
                l = g;
            end
            m_gnt <= g; m_last <= l; m_gap <= gp; m_stall <= st; m_fcnt <= f; m_to <= t;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en && !RST) begin : cmp
            logic [3:0] r, es, ebp;
            r   = m_req();
            es  = (m_gnt >= 0) ? 4'(1 << m_gnt) : 4'b0;
            ebp = (es & {4{Q_BP}}) | (r & ~es);
            chk("src_port", SRC_PORT, es);
            chk("busy", BUSY, (m_gnt >= 0) || (m_gap > 0));
            chk("timeout", TIMEOUT, m_to);
            chk("frame_cnt", FRAME_CNT, m_fcnt);
            chk("d_bp", D_BP, ebp);
            chk("pending", PENDING, r & ~es);
            chk("onehot", $countones(SRC_PORT) <= 1, 1);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic clr();
        D_SOF = '0; D_EOF = '0; D_VALID = '0; Q_BP = 1'b0; DEST = '0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2 RST = 1'b1;
        #2 RST = 1'b0;
    endtask

    initial begin : stim
        int order[$];
        int beats[4];
        logic [3:0] prev;
        bit seen;
        int n;

        clr();
        #1 RST = 1'b1;
        @(posedge CLK);
        #2 RST = 1'b0;
        chk_en = 1'b1;

        // Single requester, 5-beat frame, gap then idle
        D_SOF[2] = 1'b1; DEST[2] = 8'd1;
        tick();
        chk("t1_grant", SRC_PORT, 4'b0100);
        chk("t1_busy", BUSY, 1'b1);
        chk("t1_dbp", D_BP, 4'b0000);
        D_SOF = '0; D_VALID[2] = 1'b1;
        repeat (4) tick();
        D_EOF[2] = 1'b1;
        tick();
        chk("t1_release", SRC_PORT, 4'b0000);
        chk("t1_fcnt", FRAME_CNT, 16'd1);
        chk("t1_gap_busy", BUSY, 1'b1);
        clr();
        tick();
        chk("t1_gap2_busy", BUSY, 1'b1);
        tick();
        chk("t1_idle", BUSY, 1'b0);

        // Four contending requesters, 3-beat frames
        do_reset();
        D_SOF = 4'b1111; DEST = {8'd1, 8'd1, 8'd1, 8'd1};
        prev = 4'b0;
        for (int i = 0; i < 4; i++) beats[i] = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 0) begin
                chk("t2_pending", PENDING, 4'b1110);
                chk("t2_dbp", D_BP, 4'b1110);
            end
            if (SRC_PORT != 4'b0 && SRC_PORT != prev) order.push_back($clog2(SRC_PORT));
            prev = SRC_PORT;
            for (int i = 0; i < 4; i++) begin
                if (SRC_PORT[i]) begin
                    beats[i]++;
                    D_SOF[i] = (beats[i] == 1); D_VALID[i] = 1'b1; D_EOF[i] = (beats[i] == 3);
                end else begin
                    beats[i] = 0;
                    D_SOF[i] = 1'b1; D_VALID[i] = 1'b0; D_EOF[i] = 1'b0;
                end
            end
        end
        chk("t2_ngrants", order.size() >= 5, 1);
        if (order.size() >= 5) begin
            chk("t2_order0", order[0], 0);
            chk("t2_order1", order[1], 1);
            chk("t2_order2", order[2], 2);
            chk("t2_order3", order[3], 3);
            chk("t2_order4", order[4], 0);
        end

        // Request for another output port is ignored
        clr();
        do_reset();
        D_SOF[1] = 1'b1; DEST[1] = 8'd3;
        tick();
        chk("t3_src", SRC_PORT, 4'b0000);
        chk("t3_pending", PENDING, 4'b0000);
        chk("t3_dbp", D_BP, 4'b0000);
        chk("t3_busy", BUSY, 1'b0);

        // Single-beat frame
        clr();
        do_reset();
        D_SOF[3] = 1'b1; D_EOF[3] = 1'b1; D_VALID[3] = 1'b1; DEST[3] = 8'd1;
        tick();
        chk("t5_grant", SRC_PORT, 4'b1000);
        tick();
        chk("t5_release", SRC_PORT, 4'b0000);
        chk("t5_fcnt", FRAME_CNT, 16'd1);
        clr();
        repeat (3) tick();

        // Watchdog: held off by Q_BP, then fires after 255 stalled cycles
        D_SOF[0] = 1'b1; DEST[0] = 8'd1;
        tick();
        chk("t4_grant", SRC_PORT, 4'b0001);
        D_SOF = '0; Q_BP = 1'b1;
        seen = 1'b0;
        repeat (400) begin
            tick();
            if (TIMEOUT) seen = 1'b1;
        end
        chk("t4_no_timeout_bp", seen, 1'b0);
        chk("t4_still_granted", SRC_PORT, 4'b0001);
        Q_BP = 1'b0;
        n = 0;
        while (!TIMEOUT && n < 300) begin
            tick();
            n++;
        end
        chk("t4_timeout_latency", n, TMAX);
        chk("t4_src_cleared", SRC_PORT, 4'b0000);
        chk("t4_fcnt_kept", FRAME_CNT, 16'd1);
        tick();
        chk("t4_pulse_one_cycle", TIMEOUT, 1'b0);
        repeat (3) tick();

        // Asynchronous reset in the middle of a grant
        D_SOF[1] = 1'b1; DEST[1] = 8'd1;
        tick();
        chk("t6_grant", SRC_PORT, 4'b0010);
        D_SOF = '0; D_VALID[1] = 1'b1;
        tick();
        #1 RST = 1'b1;
        #1;
        chk("t6_rst_src", SRC_PORT, 4'b0000);
        chk("t6_rst_busy", BUSY, 1'b0);
        chk("t6_rst_fcnt", FRAME_CNT, 16'd0);
        RST = 1'b0;
        clr();
        D_SOF[0] = 1'b1; D_SOF[1] = 1'b1; DEST[0] = 8'd1; DEST[1] = 8'd1;
        tick();
        chk("t6_after_rst", SRC_PORT, 4'b0001);

        // Randomized traffic with periodic dead stretches to hit the watchdog
        clr();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                D_SOF[i]   = ($urandom % 3) == 0;
                DEST[i]    = (($urandom % 4) != 0) ? 8'd1 : 8'($urandom % 256);
                D_VALID[i] = ($urandom % 2) == 0;
                D_EOF[i]   = ($urandom % 4) == 0;
            end
            Q_BP = ($urandom % 10) == 0;
            if ((c % 1000) >= 600 && (c % 1000) < 900) begin
                D_VALID = '0;
                Q_BP    = 1'b0;
            end
        end

        clr();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
